// File: rtl/rom_dl_pkg.sv
//------------------------------------------------------------------------------
// Module  : rom_dl_pkg
// Brief   : Shared types, region bases and region decode for the ROM download
//           scheduler.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package rom_dl_pkg;

    typedef enum logic [1:0] {REG_P1, REG_P2, REG_CORE, REG_NONE} region_t;
    typedef enum logic [0:0] {IDLE, WAIT} state_t;

    localparam logic [24:0] c_p1_base   = 25'h00000;
    localparam logic [24:0] c_p2_base   = 25'h10000;
    localparam logic [24:0] c_core_base = 25'h20000;

    typedef struct packed {
        logic [24:0] addr;
        logic [7:0]  data;
    } dl_entry_t;

    // Each region is a 64 KB window starting at its base.
    function automatic logic in_window(input logic [24:0] addr, input logic [24:0] base);
        logic [24:0] off;
        off = addr - base;
        return (addr >= base) && (off[24:16] == 9'd0);
    endfunction

    function automatic region_t decode_region(input logic [24:0] addr,
                                              input logic [24:0] p1_base,
                                              input logic [24:0] p2_base,
                                              input logic [24:0] core_base);
        if (in_window(addr, p1_base))   return REG_P1;
        if (in_window(addr, p2_base))   return REG_P2;
        if (in_window(addr, core_base)) return REG_CORE;
        return REG_NONE;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rom_dl_fifo.sv
//------------------------------------------------------------------------------
// Module  : rom_dl_fifo
// Brief   : Synchronous download-byte FIFO; push and pop may coincide when full.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rom_dl_fifo
    import rom_dl_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk_sys,
    input  logic      res_n_i,
    input  logic      push,
    input  dl_entry_t push_data,
    input  logic      pop,
    output dl_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam int unsigned c_ptr_w = $clog2(DEPTH);
    localparam int unsigned c_cnt_w = c_ptr_w + 1;

    dl_entry_t          r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign full      = (r_count == c_cnt_w'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_do_pop  = pop & ~empty;
    // A pop frees the slot the push needs, so a full FIFO still accepts.
    assign w_do_push = push & (~full | w_do_pop);
    assign head      = r_mem[r_rd_ptr];

    always_ff @(posedge clk_sys) begin
        if (w_do_push) r_mem[r_wr_ptr] <= push_data;
    end

    always_ff @(posedge clk_sys or negedge res_n_i) begin
        if (!res_n_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/rom_dl_sched.sv
//------------------------------------------------------------------------------
// Module  : rom_dl_sched
// Brief   : Routes ROM download bytes to SDRAM port1/port2 or the core bus,
//           and generates rom_loaded / core_reset. Option: ROM_CHECKSUM_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rom_dl_sched
    import rom_dl_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [24:0] P1_BASE    = c_p1_base,
    parameter logic [24:0] P2_BASE    = c_p2_base,
    parameter logic [24:0] CORE_BASE  = c_core_base,
    parameter int unsigned RESET_HOLD = 16
) (
    input  logic        clk_sys,
    input  logic        res_n_i,
    input  logic        ioctl_downl,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        status_rst,
    output logic        port1_req,
    input  logic        port1_ack,
    output logic [22:0] port1_a,
    output logic [1:0]  port1_ds,
    output logic        port1_we,
    output logic [15:0] port1_d,
    output logic        port2_req,
    input  logic        port2_ack,
    output logic [22:0] port2_a,
    output logic [1:0]  port2_ds,
    output logic        port2_we,
    output logic [15:0] port2_d,
    output logic        core_wr,
    output logic [15:0] core_addr,
    output logic [7:0]  core_dout,
    output logic        rom_loaded,
    output logic        core_reset,
    output logic        busy,
    output logic        overflow
`ifdef ROM_CHECKSUM_EN
    ,
    output logic [15:0] checksum
`endif
);

    localparam int unsigned c_hold_w = $clog2(RESET_HOLD + 1);

    logic r_wr_d, r_wr_d2, r_downl_d, r_dl_seen, r_sel_p2;
    dl_entry_t r_cap;
    state_t r_state, w_state_nxt;
    logic w_push, w_pop, w_full, w_empty, w_drop, w_downl_rise;
    logic w_issue_p1, w_issue_p2, w_core_wr, w_done, w_ack_match;
    dl_entry_t w_head;
    region_t w_region;
    logic [24:0] w_base;
    logic [15:0] w_offset;

    logic r_port1_req, r_port1_we, r_port2_req, r_port2_we;
    logic [22:0] r_port1_a, r_port2_a;
    logic [1:0]  r_port1_ds, r_port2_ds;
    logic [15:0] r_port1_d, r_port2_d;
    logic r_core_wr, r_rom_loaded, r_core_reset, r_overflow;
    logic [15:0] r_core_addr;
    logic [7:0]  r_core_dout;
    logic [c_hold_w-1:0] r_hold_cnt;

    assign w_push       = r_wr_d & ~r_wr_d2 & ioctl_downl;
    assign w_drop       = w_push & w_full & ~w_pop;
    assign w_downl_rise = ioctl_downl & ~r_downl_d;
    assign w_region     = decode_region(w_head.addr, P1_BASE, P2_BASE, CORE_BASE);
    assign w_ack_match  = r_sel_p2 ? (port2_ack == r_port2_req) : (port1_ack == r_port1_req);

    rom_dl_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_sys   (clk_sys),
        .res_n_i   (res_n_i),
        .push      (w_push),
        .push_data (r_cap),
        .pop       (w_pop),
        .head      (w_head),
        .full      (w_full),
        .empty     (w_empty)
    );

    always_comb begin
        w_base = '0;
        case (w_region)
            REG_P1:   w_base = P1_BASE;
            REG_P2:   w_base = P2_BASE;
            REG_CORE: w_base = CORE_BASE;
            default:  w_base = '0;
        endcase
        w_offset = 16'(w_head.addr - w_base);
    end

    always_ff @(posedge clk_sys or negedge res_n_i) begin
        if (!res_n_i) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_issue_p1  = 1'b0;
        w_issue_p2  = 1'b0;
        w_core_wr   = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    case (w_region)
                        REG_P1:   begin w_issue_p1 = 1'b1; w_state_nxt = WAIT; end
                        REG_P2:   begin w_issue_p2 = 1'b1; w_state_nxt = WAIT; end
                        REG_CORE: w_core_wr = 1'b1;
                        default:  ;
                    endcase
                end
            end
            WAIT: begin
                if (w_ack_match) begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                    // Only non-SDRAM entries drain alongside the completion cycle.
                    if (!w_empty && (w_region == REG_CORE || w_region == REG_NONE)) begin
                        w_pop     = 1'b1;
                        w_core_wr = (w_region == REG_CORE);
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge res_n_i) begin
        if (!res_n_i) begin
            r_wr_d <= 1'b0;  r_wr_d2 <= 1'b0;  r_downl_d <= 1'b0;
            r_dl_seen <= 1'b0;  r_sel_p2 <= 1'b0;  r_cap <= '0;
            r_port1_req <= 1'b0;  r_port1_we <= 1'b0;  r_port1_a <= '0;
            r_port1_ds <= '0;  r_port1_d <= '0;
            r_port2_req <= 1'b0;  r_port2_we <= 1'b0;  r_port2_a <= '0;
            r_port2_ds <= '0;  r_port2_d <= '0;
            r_core_wr <= 1'b0;  r_core_addr <= '0;  r_core_dout <= '0;
            r_rom_loaded <= 1'b0;  r_core_reset <= 1'b1;
            r_overflow <= 1'b0;  r_hold_cnt <= '0;
        end else begin
            r_wr_d    <= ioctl_wr;
            r_wr_d2   <= r_wr_d;
            r_downl_d <= ioctl_downl;
            r_cap     <= '{addr: ioctl_addr, data: ioctl_dout};
            if (ioctl_downl) r_dl_seen <= 1'b1;

            if (w_downl_rise) r_overflow <= 1'b0;
            if (w_drop)       r_overflow <= 1'b1;

            if (w_issue_p1) begin
                r_port1_req <= ~r_port1_req;
                r_port1_we  <= 1'b1;
                r_port1_a   <= {8'd0, w_offset[15:1]};
                r_port1_ds  <= {w_offset[0], ~w_offset[0]};
                r_port1_d   <= {w_head.data, w_head.data};
                r_sel_p2    <= 1'b0;
            end
            if (w_issue_p2) begin
                r_port2_req <= ~r_port2_req;
                r_port2_we  <= 1'b1;
                r_port2_a   <= {8'd0, w_offset[15:1]};
                r_port2_ds  <= {w_offset[0], ~w_offset[0]};
                r_port2_d   <= {w_head.data, w_head.data};
                r_sel_p2    <= 1'b1;
            end
            if (w_done) begin
                if (r_sel_p2) r_port2_we <= 1'b0;
                else          r_port1_we <= 1'b0;
            end

            r_core_wr <= w_core_wr;
            if (w_core_wr) begin
                r_core_addr <= w_offset;
                r_core_dout <= w_head.data;
            end

            if (r_dl_seen && !ioctl_downl && w_empty && r_state == IDLE)
                r_rom_loaded <= 1'b1;

            if (status_rst)              r_hold_cnt <= c_hold_w'(RESET_HOLD);
            else if (r_hold_cnt != '0)   r_hold_cnt <= r_hold_cnt - 1'b1;
            r_core_reset <= status_rst | ioctl_downl | ~r_rom_loaded | (r_hold_cnt != '0);
        end
    end

`ifdef ROM_CHECKSUM_EN
    logic [15:0] r_checksum;

    always_ff @(posedge clk_sys or negedge res_n_i) begin
        if (!res_n_i)                                       r_checksum <= '0;
        else if (w_downl_rise)                              r_checksum <= '0;
        else if (w_push && !w_drop && !r_rom_loaded)        r_checksum <= r_checksum + {8'd0, r_cap.data};
    end

    assign checksum = r_checksum;
`endif

    assign port1_req  = r_port1_req;
    assign port1_we   = r_port1_we;
    assign port1_a    = r_port1_a;
    assign port1_ds   = r_port1_ds;
    assign port1_d    = r_port1_d;
    assign port2_req  = r_port2_req;
    assign port2_we   = r_port2_we;
    assign port2_a    = r_port2_a;
    assign port2_ds   = r_port2_ds;
    assign port2_d    = r_port2_d;
    assign core_wr    = r_core_wr;
    assign core_addr  = r_core_addr;
    assign core_dout  = r_core_dout;
    assign rom_loaded = r_rom_loaded;
    assign core_reset = r_core_reset;
    assign overflow   = r_overflow;
    assign busy       = ~w_empty | (r_state != IDLE);

endmodule

`default_nettype wire
